// File: rtl/alarm_pkg.sv
// Shared types for the alarm trigger: FSM state encoding and time-field widths.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

endpackage

// File: rtl/alarm_time_match.sv
// Alarm time compare with rising-edge detect: trigger pulses once per match
// window, so a held match (e.g. after stop) cannot re-arm the ring.
module alarm_time_match
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic              trigger
);

  logic match;
  logic match_q;

  assign match = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min)
                 && (cur_sec == '0);

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  assign trigger = match & ~match_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm FSM: ring / snooze / timeout on the 1 Hz tick, registered outputs.
// Optional macro ALARM_BLINK_EN: res blinks on each tick while ringing.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              stop,
  output logic              res,
  output logic              ringing,
  output logic              snoozing
);

  localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
  localparam int UW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [UW-1:0] SNZ_MAX   = UW'(MAX_SNOOZE);

  state_t        state_q, state_n;
  logic [RW-1:0] ring_cnt, ring_n;
  logic [SW-1:0] snz_cnt, snz_n;
  logic [UW-1:0] snooze_used, used_n;
  logic          res_n;
  logic          trigger;

  alarm_time_match u_match (
    .clk        (clk),
    .rst        (rst),
    .alarm_en   (alarm_en),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .trigger    (trigger)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      snooze_used <= '0;
      res         <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state_q     <= state_n;
      ring_cnt    <= ring_n;
      snz_cnt     <= snz_n;
      snooze_used <= used_n;
      res         <= res_n;
      ringing     <= (state_n == RINGING);
      snoozing    <= (state_n == SNOOZE);
    end
  end

  always_comb begin
    state_n = state_q;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    used_n  = snooze_used;
    if (!alarm_en) begin
      state_n = IDLE;
      ring_n  = '0;
      snz_n   = '0;
      used_n  = '0;
    end else begin
      case (state_q)
        IDLE:  state_n = ARMED;
        ARMED: begin
          if (trigger) begin
            state_n = RINGING;
            ring_n  = '0;
            used_n  = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_n = ARMED;
          end else if (snooze && (snooze_used < SNZ_MAX)) begin
            state_n = SNOOZE;
            snz_n   = '0;
            used_n  = snooze_used + 1'b1;
          end else if (tick_1hz) begin
            if (ring_cnt == RING_LAST) state_n = ARMED;
            else                       ring_n  = ring_cnt + 1'b1;
          end
        end
        SNOOZE: begin
          // A snooze press here is a no-op, so the tick still counts.
          if (stop) begin
            state_n = ARMED;
          end else if (tick_1hz) begin
            if (snz_cnt == SNZ_LAST) begin
              state_n = RINGING;
              ring_n  = '0;
            end else begin
              snz_n = snz_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  always_comb begin
    res_n = 1'b0;
    if (state_n == RINGING) begin
      if (state_q != RINGING) res_n = 1'b1;
      else if (tick_1hz)      res_n = ~res;
      else                    res_n = res;
    end
  end
`else
  always_comb begin
    res_n = (state_n == RINGING);
  end
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: vector table plus timeout/snooze sequences.
module tb_alarm_trigger;
  import alarm_pkg::*;

  logic              clk = 1'b0;
  logic              rst, tick_1hz, alarm_en, snooze, stop;
  logic [HOUR_W-1:0] cur_hour, alarm_hour;
  logic [MIN_W-1:0]  cur_min, alarm_min;
  logic [SEC_W-1:0]  cur_sec;
  logic              res, ringing, snoozing;

  int n_chk  = 0;
  int n_fail = 0;
  logic bphase    = 1'b0;
  logic prev_ring = 1'b0;

  typedef struct {
    logic              r, en;
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    logic              sz, sp, tk;
    logic              e_res, e_ring, e_snz;
  } vec_t;

  vec_t tbl[$];

  alarm_trigger dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .snooze(snooze), .stop(stop),
    .res(res), .ringing(ringing), .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic en, input logic [HOUR_W-1:0] h,
                              input logic [MIN_W-1:0] m, input logic [SEC_W-1:0] s,
                              input logic sz, input logic sp, input logic tk,
                              input logic er, input logic erg, input logic esz);
    vec_t v;
    v.r = r; v.en = en; v.h = h; v.m = m; v.s = s;
    v.sz = sz; v.sp = sp; v.tk = tk;
    v.e_res = er; v.e_ring = erg; v.e_snz = esz;
    return v;
  endfunction

  task automatic cmp(input string name, input string sig, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %0b want %0b", name, sig, got, want);
    end
  endtask

  // Drive one cycle of inputs, then check the registered outputs after the edge.
  task automatic apply(input vec_t v, input string name);
    logic er;
    rst = v.r; alarm_en = v.en; cur_hour = v.h; cur_min = v.m; cur_sec = v.s;
    snooze = v.sz; stop = v.sp; tick_1hz = v.tk;
    @(posedge clk);
    #1;
`ifdef ALARM_BLINK_EN
    if (v.e_ring && !prev_ring) bphase = 1'b1;
    else if (v.e_ring && v.tk)  bphase = ~bphase;
    er = v.e_ring & bphase;
`else
    er = v.e_res;
`endif
    prev_ring = v.e_ring;
    cmp(name, "res",      res,      er);
    cmp(name, "ringing",  ringing,  v.e_ring);
    cmp(name, "snoozing", snoozing, v.e_snz);
  endtask

  // One tick cycle followed by a quiet cycle, both with the same expectation.
  task automatic tick(input logic erg, input logic esz, input string name);
    apply(mk(0, 1, 7, 30, 1, 0, 0, 1, erg, erg, esz), name);
    apply(mk(0, 1, 7, 30, 1, 0, 0, 0, erg, erg, esz), name);
  endtask

  task automatic ring_up(input string name);
    apply(mk(0, 1, 7, 29, 59, 0, 0, 1, 0, 0, 0), {name, "_pre"});
    apply(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0), {name, "_trig"});
  endtask

  task automatic press(input logic sz, input logic sp, input logic erg, input logic esz,
                       input string name);
    apply(mk(0, 1, 7, 30, 1, sz, sp, 0, erg, erg, esz), name);
  endtask

  initial begin
    rst = 1'b1; alarm_en = 1'b0; tick_1hz = 1'b0; snooze = 1'b0; stop = 1'b0;
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
    alarm_hour = 5'd7; alarm_min = 6'd30;

    //              r en  h  m   s  sz sp tk  res ring snz
    tbl.push_back(mk(1, 0, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 1 IDLE->ARMED
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 1, 0, 0, 0)); // 2
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 1, 1, 1, 0)); // 3 trigger
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0)); // 4
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 1, 0, 0, 0, 0)); // 5 stop
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 0, 0, 0)); // 6 no re-trigger
    tbl.push_back(mk(0, 1, 7, 30, 1,  0, 0, 1, 0, 0, 0)); // 7
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 8
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0)); // 9
    tbl.push_back(mk(0, 1, 7, 30, 1,  1, 1, 0, 0, 0, 0)); // 10 stop beats snooze
    tbl.push_back(mk(0, 1, 7, 30, 2,  1, 0, 0, 0, 0, 0)); // 11 snooze in ARMED
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 12
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0)); // 13
    tbl.push_back(mk(0, 1, 7, 30, 1,  1, 0, 0, 0, 0, 1)); // 14 snooze
    tbl.push_back(mk(0, 1, 7, 30, 1,  0, 0, 1, 0, 0, 1)); // 15
    tbl.push_back(mk(0, 1, 7, 30, 1,  1, 0, 0, 0, 0, 1)); // 16 snooze ignored
    tbl.push_back(mk(0, 1, 7, 30, 1,  0, 1, 0, 0, 0, 0)); // 17 stop from SNOOZE
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 18
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0)); // 19
    tbl.push_back(mk(0, 1, 7, 30, 1,  1, 0, 0, 0, 0, 1)); // 20
    tbl.push_back(mk(0, 0, 7, 30, 1,  0, 0, 0, 0, 0, 0)); // 21 disable
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 0, 0, 0)); // 22 re-enable on match: IDLE
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 0, 0, 0)); // 23 held match, no trigger
    tbl.push_back(mk(0, 1, 7, 30, 1,  0, 0, 1, 0, 0, 0)); // 24
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, 0, 0, 0, 0)); // 25
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 1, 1, 0)); // 26
    tbl.push_back(mk(1, 1, 7, 30, 0,  0, 0, 0, 0, 0, 0)); // 27 reset mid-ring
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 0, 0, 0, 0)); // 28 IDLE->ARMED
    tbl.push_back(mk(0, 1, 7, 30, 0,  0, 0, 1, 0, 0, 0)); // 29

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: drops exactly on the 60th tick.
    ring_up("tmo");
    for (int i = 1; i < 60; i++) tick(1, 0, $sformatf("tmo_t%0d", i));
    tick(0, 0, "tmo_t60");

    // Snooze at tick 10, re-ring after 300 ticks for a full 60 ticks.
    ring_up("snz");
    for (int i = 1; i <= 10; i++) tick(1, 0, $sformatf("snz_r%0d", i));
    press(1, 0, 0, 1, "snz_press");
    for (int i = 1; i < 300; i++) tick(0, 1, $sformatf("snz_s%0d", i));
    tick(1, 0, "snz_s300");
    for (int i = 1; i < 60; i++) tick(1, 0, $sformatf("snz_rr%0d", i));
    tick(0, 0, "snz_rr60");

    // Snooze limit: fourth press is ignored.
    ring_up("lim");
    for (int k = 0; k < 3; k++) begin
      press(1, 0, 0, 1, $sformatf("lim_press%0d", k));
      for (int i = 1; i < 300; i++) tick(0, 1, $sformatf("lim%0d_s%0d", k, i));
      tick(1, 0, $sformatf("lim%0d_s300", k));
    end
    press(1, 0, 1, 0, "lim_press3_ignored");
    press(0, 1, 0, 0, "lim_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
